// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, status bit positions and default divider
package uart_pkg;
    localparam int DEFAULT_BAUD_DIVIDER = 868;
    localparam int FULL_BIT = 8;
    localparam int FERR_BIT = 9;
    localparam int OVR_BIT  = 10;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    function automatic logic [31:0] status_word(logic [7:0] b, logic f, logic fe, logic ov);
        status_word = 32'(b);
        status_word[FULL_BIT] = f;
        status_word[FERR_BIT] = fe;
        status_word[OVR_BIT]  = ov;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for an asynchronous idle-high input
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) {q, meta} <= 2'b11;
        else         {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-byte buffer and sticky error flags
// on a picorv32-style memory bus.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIVIDER = DEFAULT_BAUD_DIVIDER
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);
    localparam int TW = $clog2(BAUD_DIVIDER + 1);
    localparam logic [TW-1:0] BIT_END = TW'(BAUD_DIVIDER);
    localparam logic [TW-1:0] BIT_MID = TW'(BAUD_DIVIDER / 2);

    rx_state_t state, state_next;
    logic rxs, rdy, full, frame_err, overrun;
    logic sample, deliver, ferr_evt, start_acc, rd, wr;
    logic [TW-1:0] bit_timer;
    logic [2:0] bit_count;
    logic [7:0] shifter, buffer;
    logic [31:0] rdata_reg;
    logic unused;

    assign unused = ^{mem_instr, mem_wdata, mem_addr};

    uart_rx_sync u_sync (.clk(clk), .resetn(resetn), .d(serialIn), .q(rxs));

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= RX_IDLE;
        else         state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  state_next = rxs ? RX_IDLE : RX_START;
            RX_START: if (bit_timer == BIT_MID) state_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_timer == BIT_END && bit_count == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (bit_timer == BIT_END) state_next = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: state_next = rxs ? RX_IDLE : RX_BREAK;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        sample   = state == RX_DATA && bit_timer == BIT_END;
        deliver  = state == RX_STOP && bit_timer == BIT_END && rxs;
        ferr_evt = state == RX_STOP && bit_timer == BIT_END && !rxs;
    end

    // Side effects only on the rdy rising edge, so a held valid pops once
    assign start_acc = mem_valid && enable && !rdy;
    assign rd = start_acc && mem_wstrb == 4'd0;
    assign wr = start_acc && mem_wstrb != 4'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_timer <= '0;
            bit_count <= '0;
            shifter   <= '0;
            buffer    <= '0;
            full      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rdy       <= 1'b0;
            rdata_reg <= '0;
        end else begin
            bit_timer <= (state_next != state || bit_timer == BIT_END) ? '0 : bit_timer + 1'b1;
            bit_count <= state == RX_START ? '0 : bit_count + 3'(sample);
            if (sample) shifter <= {rxs, shifter[7:1]};
            rdy <= mem_valid & enable;
            if (rd) rdata_reg <= status_word(buffer, full, frame_err, overrun);
            // A pop in the same cycle frees the buffer for the arriving byte
            if (deliver && (!full || rd)) buffer <= shifter;
            full      <= deliver | (full & ~rd);
            frame_err <= ferr_evt | (frame_err & ~(rd | wr));
            overrun   <= (deliver & full & ~rd) | (overrun & ~(rd | wr));
        end
    end

    assign mem_rdata = enable ? rdata_reg : 'z;
    assign mem_ready = enable ? rdy : 1'bz;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx against a behavioural
// buffer/flag model, driven by a bit-level serial transmitter.
module tb_uart_rx;
    localparam int BD = 15;
    localparam int BP = BD + 1;

    logic clk = 1'b0, resetn = 1'b0, enable = 1'b1, mem_valid = 1'b0, mem_instr = 1'b0;
    logic serial_in = 1'b1;
    logic [3:0] mem_wstrb = 4'd0;
    logic [31:0] mem_wdata = 32'd0, mem_addr = 32'd0;
    tri1 mem_ready;
    tri1 [31:0] mem_rdata;

    int errors = 0, checks = 0;
    logic [7:0] m_buf;
    logic m_full, m_ferr, m_ovr, prev_rdy = 1'b0;
    logic [31:0] m_rdata;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIVIDER(BD)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .serialIn(serial_in)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_buf = 8'd0; m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_rdata = 32'd0;
    endfunction

    function automatic void m_deliver(input logic [7:0] b);
        if (m_full) m_ovr = 1'b1;
        else begin m_buf = b; m_full = 1'b1; end
    endfunction

    function automatic void m_read();
        m_rdata = {21'd0, m_ovr, m_ferr, m_full, m_buf};
        exp_q.push_back(m_rdata);
        m_full = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endfunction

    function automatic void m_write();
        exp_q.push_back(m_rdata);
        m_ferr = 1'b0; m_ovr = 1'b0;
    endfunction

    // Monitor: every new acknowledge is matched against the next expected word
    always @(posedge clk) begin
        #1;
        if (enable && mem_ready === 1'b1 && !prev_rdy) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got rdata %h with no transaction pending", mem_rdata);
            end else check("rdata", mem_rdata, exp_q.pop_front());
        end
        prev_rdy = enable && mem_ready === 1'b1;
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        @(negedge clk);
        serial_in = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            repeat (BP) @(negedge clk);
        end
        serial_in = stop_ok;
        repeat (BP) @(negedge clk);
        if (stop_ok) m_deliver(d);
        else begin
            repeat (BP) @(negedge clk);
            m_ferr = 1'b1;
        end
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_xfer(input logic wr);
        mem_wstrb = wr ? 4'($urandom_range(1, 15)) : 4'd0;
        mem_wdata = $urandom;
        mem_addr = $urandom;
        mem_valid = 1'b1;
        if (wr) m_write(); else m_read();
        @(negedge clk);
        check("ready_lat", mem_ready, 1);
        mem_valid = 1'b0;
        @(negedge clk);
        check("ready_drop", mem_ready, 0);
    endtask

    task automatic bus_hold();
        mem_wstrb = 4'd0;
        mem_valid = 1'b1;
        m_read();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ready", mem_ready, 1);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        check("hold_drop", mem_ready, 0);
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", mem_ready, 0);
        check("rst_rdata", mem_rdata, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        send_byte(8'hA5, 1'b1);
        bus_xfer(1'b0);
        bus_xfer(1'b0);

        send_byte(8'h3C, 1'b1);
        send_byte(8'h7E, 1'b1);
        bus_xfer(1'b0);
        bus_xfer(1'b0);

        send_byte(8'h55, 1'b0);
        bus_xfer(1'b0);
        send_byte(8'h12, 1'b1);
        bus_xfer(1'b0);

        // Short low glitch must be rejected at the mid-start check
        @(negedge clk);
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        repeat (2 * BP) @(negedge clk);
        bus_xfer(1'b0);

        send_byte(8'h99, 1'b1);
        bus_hold();
        bus_xfer(1'b0);

        enable = 1'b0;
        #1;
        check("hiz_rdata", mem_rdata, 32'hFFFF_FFFF);
        check("hiz_ready", mem_ready, 1);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        bus_xfer(1'b1);
        bus_xfer(1'b0);

        // Asynchronous reset in the middle of the data bits
        @(negedge clk);
        serial_in = 1'b0;
        repeat (3 * BP) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("async_rst_rdata", mem_rdata, 0);
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        m_reset();
        repeat (BP) @(negedge clk);
        bus_xfer(1'b0);
        send_byte(8'h81, 1'b1);
        bus_xfer(1'b0);

        // Pop lands on the same edge as the next byte's stop-bit delivery
        send_byte(8'h44, 1'b1);
        fork
            send_byte(8'h66, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                bus_xfer(1'b0);
            end
        join
        bus_xfer(1'b0);

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0);
            else bus_xfer(op >= 8);
        end
        bus_xfer(1'b0);

        repeat (4) @(negedge clk);
        check("drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
